// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
package instr_encoder_pkg;

    // Request format codes carried on in_type
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_S = 3'd4,
        FMT_L = 3'd5
    } fmt_t;

    // Occupancy of the two-entry output FIFO
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    // One FIFO slot: encoded word plus its illegal flag
    typedef struct packed {
        logic [31:0] instr;
        logic        illegal;
    } fifo_entry_t;

    // Seven-bit major opcodes, same values as the main decoder uses
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 values that affect legality or immediate layout
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_S_HI = 3'b011;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_LWU  = 3'b110;
    localparam logic [2:0] F3_L7   = 3'b111;
    localparam logic [2:0] F3_B2   = 3'b010;
    localparam logic [2:0] F3_B3   = 3'b011;

    // Word emitted in place of an illegal request (ADDI x0,x0,0)
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_packer.sv
// Combinational field packer: request fields in, RV32I word and illegal flag out.
module instr_packer
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Immediate bits above bit 20 never reach any field; range is not checked.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];

    // Pack fields by format, flag illegal combinations, substitute NOP when illegal
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (fmt_t'(fmt))
            FMT_R: begin
                word = {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, OP_REG};
            end
            FMT_I: begin
                if (funct3 == F3_SLL || funct3 == F3_SR)
                    word = {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
                else
                    word = {imm[11:0], rs1, funct3, rd, OP_IMM};
                if (funct3 == F3_SLL && funct7_5)
                    illegal = 1'b1;
            end
            FMT_L: begin
                word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                if (funct3 == F3_LD || funct3 == F3_LWU || funct3 == F3_L7)
                    illegal = 1'b1;
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                if (funct3 >= F3_S_HI)
                    illegal = 1'b1;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                if (funct3 == F3_B2 || funct3 == F3_B3 || imm[0])
                    illegal = 1'b1;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                if (imm[0])
                    illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal)
            word = NOP_WORD;
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requests into RV32I words and queues them in a
// two-entry FIFO toward the downstream consumer, counting delivered words.
//
// state      | meaning
// FIFO_EMPTY | no word held, out_valid=0
// FIFO_ONE   | one word at the head, can still accept
// FIFO_FULL  | two words held, in_ready=0
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_type,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    fifo_state_t state, state_next;
    fifo_entry_t head, tail, packed_req;
    logic        push, pop;

    instr_packer u_packer (
        .fmt      (in_type),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .imm      (in_imm),
        .word     (packed_req.instr),
        .illegal  (packed_req.illegal)
    );

    assign in_ready    = (state != FIFO_FULL);
    assign out_valid   = (state != FIFO_EMPTY);
    assign out_instr   = head.instr;
    assign out_illegal = head.illegal;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    // FIFO occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FIFO_EMPTY;
        else
            state <= state_next;
    end

    // Occupancy next-state: push and pop together leave it unchanged
    always_comb begin
        state_next = state;
        case (state)
            FIFO_EMPTY: if (push) state_next = FIFO_ONE;
            FIFO_ONE: begin
                if (push && !pop)
                    state_next = FIFO_FULL;
                else if (pop && !push)
                    state_next = FIFO_EMPTY;
            end
            FIFO_FULL: if (pop) state_next = FIFO_ONE;
            default:   state_next = FIFO_EMPTY;
        endcase
    end

    // Slot storage: head always drives the outputs, tail shifts forward on pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                FIFO_EMPTY: if (push) head <= packed_req;
                FIFO_ONE: begin
                    if (push && pop)
                        head <= packed_req;
                    else if (push)
                        tail <= packed_req;
                end
                FIFO_FULL: if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (pop)
            count <= count + 1'b1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [15:0] count;

    typedef struct {
        logic [31:0] w;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mcount;
    int          n_vec = 0;
    int          n_err = 0;

    instr_encoder #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoding built from field positions with shifts and masks
    function automatic ent_t ref_encode(int t, int rd, int rs1, int rs2, int f3, int f7, logic [31:0] imm);
        ent_t        e;
        logic [31:0] w;
        logic [31:0] base;
        logic        bad;
        bad  = 1'b0;
        base = 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15;
        case (t)
            0: w = 32'h33 | base | 32'(rs2) << 20 | 32'(f7) << 30;
            1: begin
                if (f3 == 1 || f3 == 5)
                    w = 32'h13 | base | (imm & 32'h1F) << 20 | 32'(f7) << 30;
                else
                    w = 32'h13 | base | (imm & 32'hFFF) << 20;
                bad = (f3 == 1 && f7 == 1);
            end
            5: begin
                w   = 32'h03 | base | (imm & 32'hFFF) << 20;
                bad = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            4: begin
                w = 32'h23 | (imm & 32'h1F) << 7 | 32'(f3) << 12 | 32'(rs1) << 15
                    | 32'(rs2) << 20 | ((imm >> 5) & 32'h7F) << 25;
                bad = (f3 >= 3);
            end
            2: begin
                w = 32'h63 | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 32'hF) << 8
                    | 32'(f3) << 12 | 32'(rs1) << 15 | 32'(rs2) << 20
                    | ((imm >> 5) & 32'h3F) << 25 | ((imm >> 12) & 1) << 31;
                bad = (f3 == 2 || f3 == 3 || imm[0]);
            end
            3: begin
                w = 32'h6F | 32'(rd) << 7 | ((imm >> 12) & 32'hFF) << 12
                    | ((imm >> 11) & 1) << 20 | ((imm >> 1) & 32'h3FF) << 21
                    | ((imm >> 20) & 1) << 31;
                bad = imm[0];
            end
            default: begin
                w   = 32'h0;
                bad = 1'b1;
            end
        endcase
        e.w   = bad ? 32'h13 : w;
        e.ill = bad;
        return e;
    endfunction

    // One clock: compare DUT to model before the edge, then advance the model
    task automatic cycle();
        ent_t e;
        logic fire_in, fire_out;
        #1;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_instr", out_instr, q[0].w);
            check("out_illegal", out_illegal, q[0].ill);
        end
        check("count", count, mcount);
        e        = ref_encode(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7_5, in_imm);
        fire_in  = in_valid && (q.size() < 2);
        fire_out = out_ready && (q.size() > 0);
        @(posedge clk);
        if (fire_out) begin
            void'(q.pop_front());
            mcount++;
        end
        if (fire_in)
            q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_illegal", out_illegal, 1'b0);
        check("rst_count", count, 16'h0);
        q.delete();
        mcount = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_req();
        in_type     = 3'($urandom_range(0, 7));
        in_rd       = 5'($urandom);
        in_rs1      = 5'($urandom);
        in_rs2      = 5'($urandom);
        in_funct3   = 3'($urandom);
        in_funct7_5 = 1'($urandom);
        in_imm      = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
        if ($urandom_range(0, 3) != 0)
            in_imm[0] = 1'b0;
    endtask

    task automatic directed(input string tag, input int t, input int rd, input int rs1,
                            input int rs2, input int f3, input int f7,
                            input logic [31:0] imm, input logic [31:0] exp_w, input logic exp_ill);
        in_type = 3'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7_5 = 1'(f7); in_imm = imm;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        check({tag, "_word"}, out_instr, exp_w);
        check({tag, "_ill"}, out_illegal, exp_ill);
        cycle();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7_5 = 1'b0; in_imm = '0;
        mcount = '0;
        @(negedge clk);
        do_reset();
        check("post_rst_in_ready", in_ready, 1'b1);

        directed("r_add", 0, 3, 1, 2, 0, 0, 32'd0,  32'h002081B3, 1'b0);
        directed("r_sub", 0, 3, 1, 2, 0, 1, 32'd0,  32'h402081B3, 1'b0);
        directed("i_m1",  1, 5, 0, 0, 0, 0, -32'sd1, 32'hFFF00293, 1'b0);
        directed("s_sw",  4, 0, 1, 2, 2, 0, 32'd4,  32'h0020A223, 1'b0);
        directed("b_beq", 2, 0, 1, 2, 0, 0, 32'd8,  32'h00208463, 1'b0);
        directed("j_16",  3, 1, 0, 0, 0, 0, 32'd16, 32'h010000EF, 1'b0);
        directed("j_odd", 3, 1, 0, 0, 0, 0, 32'd17, 32'h00000013, 1'b1);
        directed("bad_t", 6, 1, 1, 1, 0, 0, 32'd0,  32'h00000013, 1'b1);
        directed("srai",  1, 4, 4, 0, 5, 1, 32'd3,  32'h40325213, 1'b0);

        // Backpressure: two accepts fill the FIFO, the third is held off
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            if (i == 2) begin
                #1;
                check("full_in_ready", in_ready, 1'b0);
            end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("bp_count", count, 16'd2);
        in_valid = 1'b1; rand_req();
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        check("bp_count3", count, 16'd3);

        // Steady push+pop while holding one word
        in_valid = 1'b1; out_ready = 1'b0; rand_req();
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_req();
            #1;
            check("one_in_ready", in_ready, 1'b1);
            check("one_out_valid", out_valid, 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Reset while full drops everything immediately
        in_valid = 1'b1; out_ready = 1'b0;
        rand_req(); cycle();
        rand_req(); cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_count", count, 16'd0);
        q.delete();
        mcount = '0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_req();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
